fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of one FIFO entry.
REQ-002 Parameter PACK_RATIO, default 4, SHALL set the FIFO entries per output word; legal range 2..16.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk_rd and rst_rd.
REQ-004 clk_rd  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rst_rd  input  1  synchronous active-low reset, sampled on the clk_rd rising edge.
REQ-006 empty  input  1  FIFO empty flag, synchronous to clk_rd.
REQ-007 data_rd  input  DATA_WIDTH  FIFO head entry, valid in the same cycle whenever empty=0 (first-word fall-through).
REQ-008 rd_en  output  1  pop request to the FIFO; combinational.
REQ-009 out_data  output  DATA_WIDTH*PACK_RATIO  packed word, registered.
REQ-010 out_valid  output  1  packed word valid, registered.
REQ-011 out_ready  input  1  downstream accept; a transfer occurs when out_valid=1 and out_ready=1.

Function
REQ-012 Define out_free = !out_valid || out_ready; define pop = rd_en (rd_en is never asserted while empty=1).
REQ-013 Internal state: accumulator of PACK_RATIO-1 entries plus a stall slot, and cnt (0..PACK_RATIO) holding the number of entries held.
REQ-014 Byte order: the first entry popped for a word SHALL occupy out_data[DATA_WIDTH-1:0], and the k-th entry SHALL occupy slice k (little-endian).
REQ-015 rd_en SHALL equal !empty && !flush_pend && (cnt<PACK_RATIO || out_free).
REQ-016 On pop with cnt<PACK_RATIO-1: store data_rd at slot cnt; cnt+1.
REQ-017 On pop with cnt==PACK_RATIO-1 and out_free: out_data <= completed word; out_valid <= 1; cnt <= 0 (one-edge latency, no bubble).
REQ-018 On pop with cnt==PACK_RATIO-1 and !out_free: store the entry; cnt <= PACK_RATIO (stalled).
REQ-019 With cnt==PACK_RATIO and out_free: load the held word into the output register; out_valid <= 1. A pop in the same cycle SHALL land in slot 0, giving cnt <= 1; otherwise cnt <= 0.
REQ-020 When out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-021 out_valid SHALL clear on a transfer when no new word is loaded in the same cycle.
REQ-022 Sustained throughput SHALL be one FIFO entry per cycle when empty=0 and out_ready=1.
REQ-023 Popped entries SHALL never be dropped or duplicated, including across stalls.

Reset
REQ-024 When rst_rd=0 at a clock edge: cnt=0, out_valid=0, out_data=0, flush_pend=0, and the accumulator is cleared.
REQ-025 During reset, rd_en SHALL be 0.
REQ-026 Reset mid-word SHALL discard partial and held data; the FIFO is reset by the same rst_rd.

Configuration
REQ-027 Macro FIFO_RD_PACKER_FLUSH_EN: when defined, the ports flush (input, 1) and out_keep (output, PACK_RATIO, registered, reset 0) SHALL exist.
REQ-028 With the macro, flush=1 at an edge SHALL set flush_pend; pops SHALL be blocked while flush_pend=1.
REQ-029 With the macro, when flush_pend=1, 0<cnt<PACK_RATIO, and out_free: emit a partial word with unfilled slices zero and out_keep=(1<<cnt)-1; then set cnt <= 0 and flush_pend <= 0.
REQ-030 With the macro and flush_pend=1: if cnt==0, clear flush_pend with no output; if cnt==PACK_RATIO, perform the normal full transfer first.
REQ-031 With the macro, full words SHALL carry out_keep all-ones.
REQ-032 Without the macro, the flush and out_keep ports and flush_pend SHALL be absent, and only full words are emitted.

Verification
REQ-033 Reset: rst_rd=0 for 2 cycles with empty=0 -> rd_en=0, out_valid=0, out_data=0.
REQ-034 Stream: push 0x01..0x08, out_ready=1 -> out_data 0x04030201 then 0x08070605, each valid 1 edge after its 4th pop, with no bubbles.
REQ-035 Backpressure: out_ready=0 while 8 entries are queued -> first word holds stable, 4 more pops, then rd_en=0 (cnt=4); releasing out_ready -> both words in order, 0x04030201 then 0x08070605.
REQ-036 Underflow: empty toggles every cycle -> rd_en never 1 while empty=1, and packed words remain contiguous.
REQ-037 Flush (macro on): pop 0xAA, 0xBB, then pulse flush -> out_data=0x0000BBAA, out_keep=4'b0011; flush with cnt=0 -> no output.
REQ-038 Mid-word reset: pop 3 entries, assert rst_rd, then push 0x11..0x14 -> only 0x14131211 is emitted.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if
//   Bundles the FIFO read side and the packed output stream of fifo_rd_packer.
//   Signals:
//     empty     FIFO empty flag (first-word fall-through FIFO)
//     data_rd   FIFO head entry, valid whenever empty=0
//     rd_en     pop request to the FIFO (combinational in the packer)
//     out_data  packed word, DATA_WIDTH*PACK_RATIO bits, entry 0 in the LSBs
//     out_valid packed word valid
//     out_ready downstream accept
//   With FIFO_RD_PACKER_FLUSH_EN defined, two more signals exist:
//     flush     request to emit a partially filled word
//     out_keep  one bit per slice of out_data marking the filled slices
//   Modports: master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);

  logic                             empty;
  logic [DATA_WIDTH-1:0]            data_rd;
  logic                             rd_en;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic                             out_valid;
  logic                             out_ready;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic                             flush;
  logic [PACK_RATIO-1:0]            out_keep;
`endif

`ifdef FIFO_RD_PACKER_FLUSH_EN
  modport master (
    input  empty, data_rd, out_ready, flush,
    output rd_en, out_data, out_valid, out_keep
  );
  modport slave (
    output empty, data_rd, out_ready, flush,
    input  rd_en, out_data, out_valid, out_keep
  );
`else
  modport master (
    input  empty, data_rd, out_ready,
    output rd_en, out_data, out_valid
  );
  modport slave (
    output empty, data_rd, out_ready,
    input  rd_en, out_data, out_valid
  );
`endif

endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Pops entries from a first-word fall-through FIFO and packs PACK_RATIO of
//   them into one output word, first popped entry in the least significant
//   slice. Sustains one entry per cycle; when the output register is blocked
//   the next word is completed into a stall slot and popping stops until the
//   output frees up.
//   Parameters:
//     DATA_WIDTH  width of one FIFO entry
//     PACK_RATIO  entries per output word, legal range 2..16
//   Ports:
//     clk_rd      read-domain clock, all state changes on its rising edge
//     rst_rd      synchronous active-low reset
//     bus         fifo_rd_packer_if.master (empty, data_rd, rd_en, out_data,
//                 out_valid, out_ready, and flush/out_keep when enabled)
//   Optional feature: define FIFO_RD_PACKER_FLUSH_EN to add the flush input
//   and the out_keep output, allowing a partially filled word to be emitted.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                clk_rd,
  input  logic                rst_rd,
  fifo_rd_packer_if.master    bus
);

  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK_RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK_RATIO - 1);

  typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] word_t;

  // Slots 0..PACK_RATIO-2 collect a word; the top slot is only used as the
  // stall slot that completes a word while the output register is busy.
  word_t         acc_q, acc_d;
  word_t         out_data_q, out_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_free;
  logic          pop;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic                  flush_pend_q, flush_pend_d;
  logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
`endif

  assign out_free = !out_valid_q || bus.out_ready;

  // cnt never exceeds PACK_RATIO, so "not full" is the same as cnt < PACK_RATIO.
  // Gating with rst_rd keeps the FIFO untouched while reset is asserted.
`ifdef FIFO_RD_PACKER_FLUSH_EN
  assign pop = rst_rd && !bus.empty && !flush_pend_q &&
               ((cnt_q != CNT_FULL) || out_free);
`else
  assign pop = rst_rd && !bus.empty && ((cnt_q != CNT_FULL) || out_free);
`endif

  assign bus.rd_en     = pop;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  assign bus.out_keep  = out_keep_q;
`endif

  // Next-state logic for the accumulator, the fill count and the output
  // register. A word completes either straight from the FIFO head (no bubble)
  // or from the stall slot once the output register frees up.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    flush_pend_d = flush_pend_q;
    out_keep_d   = out_keep_q;
`endif

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cnt_q == CNT_FULL) begin
      if (out_free) begin
        out_data_d  = acc_q;
        out_valid_d = 1'b1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        out_keep_d  = '1;
`endif
        if (pop) begin
          acc_d[0] = bus.data_rd;
          cnt_d    = CW'(1);
        end else begin
          cnt_d    = '0;
        end
      end
    end else if (pop) begin
      if (cnt_q == CNT_LAST) begin
        if (out_free) begin
          out_data_d                 = acc_q;
          out_data_d[PACK_RATIO-1]   = bus.data_rd;
          out_valid_d                = 1'b1;
          cnt_d                      = '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
          out_keep_d                 = '1;
`endif
        end else begin
          acc_d[PACK_RATIO-1] = bus.data_rd;
          cnt_d               = CNT_FULL;
        end
      end else begin
        for (int i = 0; i < PACK_RATIO; i++) begin
          if (cnt_q == CW'(i)) begin
            acc_d[i] = bus.data_rd;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end

`ifdef FIFO_RD_PACKER_FLUSH_EN
    // A pending flush blocks pops. A held full word drains through the normal
    // path above first; after that the count is zero and the flush retires.
    // Slots above cnt may hold stale entries from earlier words, so they are
    // zeroed explicitly in a partial word.
    if (flush_pend_q) begin
      if (cnt_q == '0) begin
        flush_pend_d = 1'b0;
      end else if ((cnt_q != CNT_FULL) && out_free) begin
        for (int i = 0; i < PACK_RATIO; i++) begin
          out_data_d[i] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
          out_keep_d[i] = (CW'(i) < cnt_q);
        end
        out_valid_d  = 1'b1;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end
    end
    if (bus.flush) begin
      flush_pend_d = 1'b1;
    end
`endif
  end

  // State registers with synchronous active-low reset; reset discards any
  // partial or held word.
  always_ff @(posedge clk_rd) begin
    if (!rst_rd) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      flush_pend_q <= 1'b0;
      out_keep_q   <= '0;
`endif
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      flush_pend_q <= flush_pend_d;
      out_keep_q   <= out_keep_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
//   Testbench for fifo_rd_packer with DATA_WIDTH=8, PACK_RATIO=4.
//   A queue models the first-word fall-through FIFO feeding the packer.
//   Directed tests push hand-computed expected words into a scoreboard queue;
//   a monitor compares every presented output word against the queue head.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;

  logic clk_rd;
  logic rst_rd;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk_rd (clk_rd),
    .rst_rd (rst_rd),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;

  logic [DW-1:0]    srcQ[$];
  logic [DW*PR-1:0] expQ[$];
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic [PR-1:0]    expKeepQ[$];
`endif
  int               xferCycles[$];

  logic popPending = 1'b0;
  logic gate       = 1'b0;
  logic toggleMode = 1'b0;

  // Free-running clock, period 10.
  initial begin
    clk_rd = 1'b0;
    forever #5 clk_rd = ~clk_rd;
  end

  // Hard stop in case something never drains.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Queue n consecutive entries starting at first into the model FIFO.
  task automatic applyStimulus(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) srcQ.push_back(first + DW'(i));
  endtask

  task automatic expWord(input logic [DW*PR-1:0] w);
    expQ.push_back(w);
`ifdef FIFO_RD_PACKER_FLUSH_EN
    expKeepQ.push_back('1);
`endif
  endtask

`ifdef FIFO_RD_PACKER_FLUSH_EN
  task automatic expPartial(input logic [DW*PR-1:0] w, input logic [PR-1:0] k);
    expQ.push_back(w);
    expKeepQ.push_back(k);
  endtask
`endif

  // Advance n rising edges and land just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_rd);
    #1;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((expQ.size() != 0 || srcQ.size() != 0) && i < 300) begin
      @(posedge clk_rd);
      i++;
    end
    #1;
    checkOutput({name, "_drain"}, 64'(expQ.size() + srcQ.size()), 64'd0);
  endtask

  task automatic waitSrcEmpty(input string name);
    int i;
    i = 0;
    while (srcQ.size() != 0 && i < 100) begin
      @(posedge clk_rd);
      i++;
    end
    #1;
    checkOutput({name, "_popped"}, 64'(srcQ.size()), 64'd0);
  endtask

  // Model FIFO: pops on the edge where rd_en was seen high, presents the new
  // head shortly after the edge, and samples rd_en at the falling edge.
  initial begin
    forever begin
      @(posedge clk_rd);
      if (popPending && srcQ.size() != 0) void'(srcQ.pop_front());
      #2;
      gate        = toggleMode ? !gate : 1'b0;
      bus.empty   = (srcQ.size() == 0) || gate;
      bus.data_rd = (srcQ.size() != 0) ? srcQ[0] : '0;
      @(negedge clk_rd);
      popPending = bus.rd_en;
      if (bus.empty) checkOutput("rd_en_while_empty", 64'(bus.rd_en), 64'd0);
    end
  end

  // Monitor: every presented word must match the scoreboard head; it is
  // retired when out_ready accepts it.
  initial begin
    forever begin
      @(negedge clk_rd);
      cycleCount++;
      if (rst_rd === 1'b1 && bus.out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, required no word", bus.out_data);
        end else begin
          checkOutput("out_data", 64'(bus.out_data), 64'(expQ[0]));
`ifdef FIFO_RD_PACKER_FLUSH_EN
          checkOutput("out_keep", 64'(bus.out_keep), 64'(expKeepQ[0]));
`endif
          if (bus.out_ready) begin
            void'(expQ.pop_front());
`ifdef FIFO_RD_PACKER_FLUSH_EN
            void'(expKeepQ.pop_front());
`endif
            xferCycles.push_back(cycleCount);
          end
        end
      end
    end
  end

  initial begin
    int startCycle;
    rst_rd        = 1'b0;
    bus.out_ready = 1'b0;
    bus.empty     = 1'b1;
    bus.data_rd   = '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    bus.flush     = 1'b0;
`endif

    // Reset with data waiting in the FIFO: nothing may be popped or emitted.
    $display("[TB] reset");
    applyStimulus(8'h01, 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_rd);
      #1;
      checkOutput("reset_rd_en", 64'(bus.rd_en), 64'd0);
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_out_data", 64'(bus.out_data), 64'd0);
`ifdef FIFO_RD_PACKER_FLUSH_EN
      checkOutput("reset_out_keep", 64'(bus.out_keep), 64'd0);
`endif
    end
    step(1);
    srcQ.delete();
    step(1);
    rst_rd = 1'b1;
    step(2);

    // Streaming at full rate.
    $display("[TB] stream");
    bus.out_ready = 1'b1;
    xferCycles.delete();
    expWord(32'h04030201);
    expWord(32'h08070605);
    startCycle = cycleCount;
    applyStimulus(8'h01, 8);
    drain("stream");
    if (xferCycles.size() >= 2) begin
      checkOutput("stream_latency", 64'(xferCycles[0] - startCycle), 64'd5);
      checkOutput("stream_interval", 64'(xferCycles[1] - xferCycles[0]), 64'd4);
    end else begin
      checkOutput("stream_transfers", 64'(xferCycles.size()), 64'd2);
    end
    step(4);

    // Backpressure: first word held, second parked in the stall slot.
    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    expWord(32'h04030201);
    expWord(32'h08070605);
    expWord(32'h0C0B0A09);
    applyStimulus(8'h01, 12);
    step(16);
    @(negedge clk_rd);
    #1;
    checkOutput("bp_rd_en", 64'(bus.rd_en), 64'd0);
    checkOutput("bp_remaining", 64'(srcQ.size()), 64'd4);
    @(posedge clk_rd);
    #1;
    bus.out_ready = 1'b1;
    drain("backpressure");
    step(4);

    // Underflow: empty toggles every cycle.
    $display("[TB] underflow");
    toggleMode = 1'b1;
    expWord(32'h24232221);
    expWord(32'h28272625);
    applyStimulus(8'h21, 8);
    drain("underflow");
    toggleMode = 1'b0;
    step(4);

`ifdef FIFO_RD_PACKER_FLUSH_EN
    // Flush of a two-entry partial word, then a flush with nothing held.
    $display("[TB] flush");
    applyStimulus(8'hAA, 1);
    applyStimulus(8'hBB, 1);
    waitSrcEmpty("flush");
    step(2);
    expPartial(32'h0000BBAA, 4'b0011);
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    drain("flush_partial");
    step(4);
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    step(6);
    expWord(32'h34333231);
    applyStimulus(8'h31, 4);
    drain("flush_after");
    step(4);
`endif

    // Reset in the middle of a word discards the partial entries.
    $display("[TB] mid-word reset");
    applyStimulus(8'hA1, 3);
    waitSrcEmpty("midreset");
    step(2);
    rst_rd = 1'b0;
    srcQ.delete();
    step(2);
    rst_rd = 1'b1;
    expWord(32'h14131211);
    applyStimulus(8'h11, 4);
    drain("midreset");
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
